// File: rtl/c7b_mem_arb_if.sv
// Bundle of IFU, LSU and memory-port signals around the c7b memory arbiter.
// The slave modport is the arbiter side; master is the surrounding fabric.
interface c7b_mem_arb_if;
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_ack;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;

    logic        lsu_req;
    logic        lsu_we;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_ack;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        err_timeout;

    modport slave (
        input  ifu_req, ifu_addr,
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wstrb,
        input  mem_ack, mem_rvalid, mem_rdata,
        output ifu_ack, ifu_rvalid, ifu_rdata,
        output lsu_ack, lsu_rvalid, lsu_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output err_timeout
    );

    modport master (
        output ifu_req, ifu_addr,
        output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wstrb,
        output mem_ack, mem_rvalid, mem_rdata,
        input  ifu_ack, ifu_rvalid, ifu_rdata,
        input  lsu_ack, lsu_rvalid, lsu_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  err_timeout
    );
endinterface

// File: rtl/c7b_mem_arb.sv
// Single-port memory arbiter between IFU and LSU, one transaction at a time,
// with LSU priority, IFU anti-starvation and a response watchdog.
module c7b_mem_arb #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic          clk,
    input  logic          reset,
    c7b_mem_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    localparam logic [7:0] TMAX = 8'(TIMEOUT);

    state_t      state;
    logic        owner_lsu;
    logic [3:0]  streak;
    logic [7:0]  wdog;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    logic        idle;
    logic        waiting;
    logic        win_lsu;
    logic        win_ifu;
    logic        tmo;
    logic        done;
    logic [31:0] rdata;

    assign idle    = (state == IDLE) && !reset;
    assign waiting = (state == WAIT) && !reset;
    // IFU only overrides LSU once the contended streak is exhausted
    assign win_lsu = bus.lsu_req && (!bus.ifu_req || streak != SMAX);
    assign win_ifu = bus.ifu_req && !win_lsu;

    assign tmo   = waiting && (TMAX != 8'd0) && (wdog == TMAX)
                && !bus.mem_rvalid;
    assign done  = waiting && (bus.mem_rvalid || tmo);
    assign rdata = (bus.mem_rvalid && !mem_we) ? bus.mem_rdata : 32'h0;

    assign bus.ifu_ack     = idle && win_ifu;
    assign bus.lsu_ack     = idle && win_lsu;
    assign bus.ifu_rvalid  = done && !owner_lsu;
    assign bus.lsu_rvalid  = done && owner_lsu;
    assign bus.ifu_rdata   = bus.ifu_rvalid ? rdata : 32'h0;
    assign bus.lsu_rdata   = bus.lsu_rvalid ? rdata : 32'h0;
    assign bus.err_timeout = tmo;

    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_wstrb = mem_wstrb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner_lsu <= 1'b0;
            streak    <= 4'd0;
            wdog      <= 8'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_lsu) begin
                        state     <= REQ;
                        owner_lsu <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= bus.lsu_we;
                        mem_addr  <= bus.lsu_addr;
                        mem_wdata <= bus.lsu_wdata;
                        mem_wstrb <= bus.lsu_we ? bus.lsu_wstrb : 4'h0;
                        if (bus.ifu_req && streak != SMAX)
                            streak <= streak + 4'd1;
                    end else if (win_ifu) begin
                        state     <= REQ;
                        owner_lsu <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= bus.ifu_addr;
                        mem_wdata <= 32'h0;
                        mem_wstrb <= 4'h0;
                        streak    <= 4'd0;
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        state   <= WAIT;
                        mem_req <= 1'b0;
                        wdog    <= 8'd0;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid || tmo)
                        state <= IDLE;
                    else if (wdog != 8'hff)
                        wdog <= wdog + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_c7b_mem_arb.sv
// Directed bench for c7b_mem_arb: routing, priority, starvation,
// watchdog abort and reset in WAIT.
module tb_c7b_mem_arb;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_pass = 0;
    int   n_chk  = 0;

    c7b_mem_arb_if bus ();

    c7b_mem_arb #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // entered in a REQ cycle; ack now, respond in the first WAIT cycle
    task automatic serve(input logic [31:0] data, input logic [31:0] exp,
                         input bit lsu);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = data;
        #1;
        chk("mreq_wait", bus.mem_req, 0);
        chk("rv_lsu", bus.lsu_rvalid, lsu);
        chk("rv_ifu", bus.ifu_rvalid, !lsu);
        chk("rdata", lsu ? bus.lsu_rdata : bus.ifu_rdata, exp);
        chk("rdata_oth", lsu ? bus.ifu_rdata : bus.lsu_rdata, 0);
        tick();
        bus.mem_rvalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [9:0] pat;
        bus.ifu_req    = 1'b1;
        bus.ifu_addr   = 32'h1c00_0000;
        bus.lsu_req    = 1'b0;
        bus.lsu_we     = 1'b0;
        bus.lsu_addr   = 32'h0;
        bus.lsu_wdata  = 32'h0;
        bus.lsu_wstrb  = 4'h0;
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;

        // reset state, even with a request pending
        tick();
        tick();
        chk("rst_ifu_ack", bus.ifu_ack, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_err", bus.err_timeout, 0);
        bus.ifu_req = 1'b0;
        reset = 1'b0;
        tick();

        // single IFU read, response two cycles after ack
        bus.ifu_req  = 1'b1;
        bus.ifu_addr = 32'h1c00_0000;
        #1;
        chk("t1_ifu_ack", bus.ifu_ack, 1);
        chk("t1_lsu_ack", bus.lsu_ack, 0);
        tick();
        bus.ifu_req = 1'b0;
        bus.mem_ack = 1'b1;
        #1;
        chk("t1_ack_req", bus.ifu_ack, 0);
        chk("t1_mem_req", bus.mem_req, 1);
        chk("t1_addr", bus.mem_addr, 32'h1c00_0000);
        chk("t1_we", bus.mem_we, 0);
        tick();
        bus.mem_ack = 1'b0;
        #1;
        chk("t1_mreq_drop", bus.mem_req, 0);
        chk("t1_rv_early", bus.ifu_rvalid, 0);
        tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0280_0405;
        #1;
        chk("t1_rv", bus.ifu_rvalid, 1);
        chk("t1_rdata", bus.ifu_rdata, 32'h0280_0405);
        chk("t1_lsu_rv", bus.lsu_rvalid, 0);
        tick();
        bus.mem_rvalid = 1'b0;

        // contention: LSU first, IFU after LSU response
        bus.ifu_req  = 1'b1;
        bus.ifu_addr = 32'h1c00_0040;
        bus.lsu_req  = 1'b1;
        bus.lsu_we   = 1'b0;
        bus.lsu_addr = 32'h1c00_0100;
        #1;
        chk("t2_lsu_ack", bus.lsu_ack, 1);
        chk("t2_ifu_ack", bus.ifu_ack, 0);
        tick();
        bus.lsu_req = 1'b0;
        #1;
        chk("t2_no_ack", bus.ifu_ack, 0);
        chk("t2_addr_l", bus.mem_addr, 32'h1c00_0100);
        serve(32'h1111_2222, 32'h1111_2222, 1'b1);
        #1;
        chk("t2_ifu_ack2", bus.ifu_ack, 1);
        tick();
        bus.ifu_req = 1'b0;
        #1;
        chk("t2_addr_i", bus.mem_addr, 32'h1c00_0040);
        serve(32'h3333_4444, 32'h3333_4444, 1'b0);

        // LSU write
        bus.lsu_req   = 1'b1;
        bus.lsu_we    = 1'b1;
        bus.lsu_addr  = 32'h1c00_0200;
        bus.lsu_wdata = 32'h0000_005a;
        bus.lsu_wstrb = 4'hf;
        #1;
        chk("t3_ack", bus.lsu_ack, 1);
        tick();
        bus.lsu_req = 1'b0;
        #1;
        chk("t3_we", bus.mem_we, 1);
        chk("t3_wdata", bus.mem_wdata, 32'h5a);
        chk("t3_wstrb", bus.mem_wstrb, 4'hf);
        chk("t3_addr", bus.mem_addr, 32'h1c00_0200);
        serve(32'hdead_beef, 32'h0, 1'b1);

        // starvation: both held, expect L,L,L,L,I,L,L,L,L,I
        pat = 10'b01111_01111;
        bus.ifu_req  = 1'b1;
        bus.ifu_addr = 32'h1c00_0300;
        bus.lsu_req  = 1'b1;
        bus.lsu_we   = 1'b0;
        bus.lsu_addr = 32'h1c00_0400;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t4_lsu_ack", bus.lsu_ack, pat[i]);
            chk("t4_ifu_ack", bus.ifu_ack, !pat[i]);
            tick();
            #1;
            chk("t4_addr", bus.mem_addr,
                pat[i] ? 32'h1c00_0400 : 32'h1c00_0300);
            serve(32'h100 + 32'(i), 32'h100 + 32'(i), pat[i]);
        end
        bus.ifu_req = 1'b0;
        bus.lsu_req = 1'b0;
        tick();

        // watchdog: no response, abort after 8 silent WAIT cycles
        bus.lsu_req  = 1'b1;
        bus.lsu_we   = 1'b0;
        bus.lsu_addr = 32'h1c00_0500;
        #1;
        chk("t5_ack", bus.lsu_ack, 1);
        tick();
        bus.lsu_req   = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hffff_ffff;
        tick();
        bus.mem_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t5_no_err", bus.err_timeout, 0);
            chk("t5_no_rv", bus.lsu_rvalid, 0);
            tick();
        end
        #1;
        chk("t5_err", bus.err_timeout, 1);
        chk("t5_rv", bus.lsu_rvalid, 1);
        chk("t5_rdata", bus.lsu_rdata, 0);
        chk("t5_ifu_rv", bus.ifu_rvalid, 0);
        tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
        #1;
        chk("t5_late_l", bus.lsu_rvalid, 0);
        chk("t5_late_i", bus.ifu_rvalid, 0);
        chk("t5_late_err", bus.err_timeout, 0);
        tick();
        bus.mem_rvalid = 1'b0;
        bus.ifu_req    = 1'b1;
        bus.ifu_addr   = 32'h1c00_0600;
        #1;
        chk("t5_next_ack", bus.ifu_ack, 1);
        tick();
        bus.ifu_req = 1'b0;
        serve(32'hcafe_f00d, 32'hcafe_f00d, 1'b0);

        // reset while in WAIT
        bus.ifu_req  = 1'b1;
        bus.ifu_addr = 32'h1c00_0700;
        tick();
        bus.ifu_req = 1'b0;
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_mem_req", bus.mem_req, 0);
        chk("t6_addr", bus.mem_addr, 0);
        tick();
        reset = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h7777_7777;
        #1;
        chk("t6_late_i", bus.ifu_rvalid, 0);
        chk("t6_late_l", bus.lsu_rvalid, 0);
        tick();
        bus.mem_rvalid = 1'b0;
        bus.ifu_req    = 1'b1;
        bus.ifu_addr   = 32'h1c00_0800;
        #1;
        chk("t6_ack", bus.ifu_ack, 1);
        tick();
        bus.ifu_req = 1'b0;
        #1;
        chk("t6_addr2", bus.mem_addr, 32'h1c00_0800);
        serve(32'h0bad_f00d, 32'h0bad_f00d, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/c7b_mem_arb.md
Name: c7b_mem_arb

Overview:
Arbitrates the core's single memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU). Runs one transaction at a time: capture, issue, await response, route response back to the owner. Sits between u_core's ifu/exu and the bus bridge inside u_c7b. LSU has priority by default; a starvation counter guarantees IFU forward progress. A response watchdog prevents lock-up.

Parameters:
STARVE_MAX, 4, consecutive contended LSU grants after which IFU wins the next contended arbitration (1..15)
TIMEOUT, 64, WAIT-state cycles before forced abort; 0 disables watchdog (max 255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
ifu_req  in  1  IFU read request; held with ifu_addr until ifu_ack
ifu_addr  in  32  IFU fetch address
ifu_ack  out  1  one-cycle pulse: IFU request captured
ifu_rvalid  out  1  IFU response valid, one cycle
ifu_rdata  out  32  IFU response data
lsu_req  in  1  LSU request; held with payload until lsu_ack
lsu_we  in  1  1=write, 0=read
lsu_addr  in  32  LSU address
lsu_wdata  in  32  LSU write data
lsu_wstrb  in  4  LSU byte strobes (writes only)
lsu_ack  out  1  one-cycle pulse: LSU request captured
lsu_rvalid  out  1  LSU response valid (read data or write-done), one cycle
lsu_rdata  out  32  LSU read data (0 for writes)
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  registered write flag
mem_addr  out  32  registered address
mem_wdata  out  32  registered write data
mem_wstrb  out  4  registered strobes (4'h0 for reads)
mem_ack  in  1  memory accepted request this cycle
mem_rvalid  in  1  memory response, exactly one per accepted request
mem_rdata  in  32  memory response data
err_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, any state): state=IDLE, owner=IFU, streak=0, wdog=0; all outputs 0, payload regs 0. In-flight transaction dropped; no rvalid emitted.
- States: IDLE, REQ, WAIT.
- IDLE: if any req, pick winner, pulse its ack (registered, cycle after req seen is NOT required: ack asserted combinationally from IDLE & req & win), latch payload and owner, go REQ. No req: stay.
- Winner: only one requesting -> it. Both -> LSU unless streak==STARVE_MAX, then IFU.
- streak: +1 (saturating at STARVE_MAX) on LSU grant while ifu_req=1; cleared on any IFU grant; unchanged otherwise.
- IFU capture sets mem_we=0, mem_wstrb=0, mem_wdata=0.
- REQ: mem_req=1, payload stable. mem_ack=1 -> WAIT next cycle, mem_req drops. mem_rvalid in REQ ignored.
- WAIT: mem_rvalid=1 -> owner rvalid=1 same cycle, rdata=mem_rdata (lsu_rdata=0 if write); go IDLE. Non-owner rvalid/rdata stay 0.
- Watchdog: wdog cleared on WAIT entry, +1 per WAIT cycle without mem_rvalid; on reaching TIMEOUT (≠0): owner rvalid=1 with rdata=0, err_timeout=1, go IDLE. rvalid on same cycle as timeout: treat as normal response, no error.
- mem_rvalid outside WAIT ignored (incl. late response after abort).
- Throughput: min 3 cycles/transaction (IDLE capture, REQ with immediate ack, WAIT with rvalid); next capture in following IDLE cycle.
- ack never asserted outside IDLE; requests arriving during REQ/WAIT wait.

Test Plan:
- Single IFU read 0x1c000000, mem_ack same cycle, rvalid 2 cycles later with 0x02800405 -> ifu_ack 1 pulse, mem_addr=0x1c000000, mem_we=0, ifu_rvalid/ifu_rdata=0x02800405, lsu_rvalid stays 0.
- ifu_req and lsu_req (read 0x1c000100) same cycle -> LSU acked first; IFU acked in IDLE after LSU response; responses routed to correct owner.
- LSU write 0x1c000200 data 0x5a wstrb 4'hf -> mem_we=1, mem_wdata=0x5a, mem_wstrb=4'hf; on rvalid lsu_rvalid=1, lsu_rdata=0.
- Both held continuously, STARVE_MAX=4 -> grant order L,L,L,L,I,L,L,L,L,I; streak clears after each IFU grant.
- TIMEOUT=8, memory never responds -> 8 WAIT cycles then owner rvalid=1 rdata=0, err_timeout pulse; late mem_rvalid ignored; next request served normally.
- reset pulsed in WAIT -> all outputs 0 immediately; later mem_rvalid ignored; post-reset IFU read completes correctly.
